// File: rtl/pr_alloc_ctrl_pkg.sv
// Shared types and sizing constants for the physical-register allocation controller.
package pr_alloc_ctrl_pkg;
  localparam int SUPERSCALAR_WAYS = 3;
  localparam int N_PHYS_REG       = 64;
  localparam int N_ARCH_REG       = 32;
  localparam int FREE_CNT_W       = $clog2(N_PHYS_REG + 1);
  localparam int PR_INIT_FREE     = N_PHYS_REG - N_ARCH_REG;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } ALLOC_CTRL_STATE;
endpackage

// File: rtl/pr_alloc_ctrl_grant.sv
// In-order dispatch grant: each way dispatches only if every older valid way did
// and the running PR demand still fits inside the allocation budget.
module inorder_alloc_grant #(
  parameter int WAYS = 3,
  parameter int CW   = 8,
  parameter int LW   = 2
) (
  input  logic [WAYS-1:0] i_disp_valid,
  input  logic [WAYS-1:0] i_needs_pr,
  input  logic [LW-1:0]   i_limit,
  input  logic [CW-1:0]   i_budget,
  output logic [WAYS-1:0] o_disp_en,
  output logic [WAYS-1:0] o_new_pr_en
);
  logic          w_blk;
  logic          w_ok;
  logic [CW-1:0] w_cnt;

  always_comb begin
    o_disp_en   = '0;
    o_new_pr_en = '0;
    w_blk       = 1'b0;
    w_ok        = 1'b0;
    w_cnt       = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_ok = !w_blk && (i < int'(i_limit)) &&
             (!i_needs_pr[i] || ((w_cnt + CW'(1)) <= i_budget));
      o_disp_en[i]   = i_disp_valid[i] & w_ok;
      o_new_pr_en[i] = i_disp_valid[i] & w_ok & i_needs_pr[i];
      if (o_new_pr_en[i]) w_cnt = w_cnt + CW'(1);
      // A held valid way stalls everything younger, PR or not.
      if (i_disp_valid[i] && !w_ok) w_blk = 1'b1;
    end
  end
endmodule

// File: rtl/pr_alloc_ctrl.sv
// Free-PR accounting and dispatch stall sequencing across reset and branch recovery.
module pr_alloc_ctrl
  import pr_alloc_ctrl_pkg::*;
#(
  parameter int WAYS          = SUPERSCALAR_WAYS,
  parameter int NPR           = N_PHYS_REG,
  parameter int NAR           = N_ARCH_REG,
  parameter int RECOVER_STALL = 1,
  localparam int FCW          = $clog2(NPR + 1),
  localparam int LW           = $clog2(WAYS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WAYS-1:0]  disp_valid,
  input  logic [WAYS-1:0]  disp_needs_pr,
  input  logic [LW-1:0]    disp_limit,
  input  logic [WAYS-1:0]  retire_valid,
  input  logic             br_recover_enable,
  input  logic [WAYS-1:0]  fl_grant_valid,
  output logic [WAYS-1:0]  new_pr_en,
  output logic [WAYS-1:0]  disp_en,
  output logic             stall,
  output logic [FCW-1:0]   free_cnt,
  output logic             low_free,
  output logic             alloc_err
);
  localparam int CW        = FCW + 1;
  localparam int INIT_FREE = NPR - NAR;
  localparam int RCW       = (RECOVER_STALL > 1) ? $clog2(RECOVER_STALL) : 1;

  ALLOC_CTRL_STATE r_state;
  logic [RCW-1:0]  r_rc;
  logic [FCW-1:0]  r_free_cnt;
  logic            r_low_free;
  logic            r_alloc_err;

  logic [LW-1:0]   w_rcnt;
  logic [LW-1:0]   w_acnt;
  logic [CW-1:0]   w_budget;
  logic [CW-1:0]   w_next;
  logic            w_over;
  logic [FCW-1:0]  w_next_clamp;
  logic            w_active;
  logic [WAYS-1:0] w_gnt_en;
  logic [WAYS-1:0] w_gnt_pr;

  always_comb begin
    w_rcnt = '0;
    w_acnt = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_rcnt = w_rcnt + LW'(retire_valid[i]);
      w_acnt = w_acnt + LW'(new_pr_en[i]);
    end
  end

  // PRs retired this cycle are already usable by this cycle's dispatch.
  assign w_budget = CW'(r_free_cnt) + CW'(w_rcnt);

  inorder_alloc_grant #(.WAYS(WAYS), .CW(CW), .LW(LW)) u_grant (
    .i_disp_valid (disp_valid),
    .i_needs_pr   (disp_needs_pr),
    .i_limit      (disp_limit),
    .i_budget     (w_budget),
    .o_disp_en    (w_gnt_en),
    .o_new_pr_en  (w_gnt_pr)
  );

  assign w_active  = (r_state == RUN) && !br_recover_enable;
  assign disp_en   = w_active ? w_gnt_en : '0;
  assign new_pr_en = w_active ? w_gnt_pr : '0;
  assign stall     = w_active ? |(disp_valid & ~w_gnt_en) : 1'b1;

  assign w_next       = w_budget - CW'(w_acnt);
  assign w_over       = w_next > CW'(INIT_FREE);
  assign w_next_clamp = w_over ? FCW'(INIT_FREE) : w_next[FCW-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= INIT;
      r_rc        <= '0;
      r_free_cnt  <= FCW'(INIT_FREE);
      r_low_free  <= 1'b0;
      r_alloc_err <= 1'b0;
    end else begin
      case (r_state)
        INIT: r_state <= RUN;
        default: begin
          if (br_recover_enable) begin
            r_free_cnt <= FCW'(INIT_FREE);
            r_low_free <= (INIT_FREE < WAYS);
            r_state    <= RECOVER;
            r_rc       <= RCW'(RECOVER_STALL - 1);
          end else if (r_state == RUN) begin
            r_free_cnt <= w_next_clamp;
            r_low_free <= w_next_clamp < FCW'(WAYS);
            if (w_over || |(new_pr_en & ~fl_grant_valid)) r_alloc_err <= 1'b1;
          end else if (r_rc == '0) begin
            r_state <= RUN;
          end else begin
            r_rc <= r_rc - RCW'(1);
          end
        end
      endcase
    end
  end

  assign free_cnt  = r_free_cnt;
  assign low_free  = r_low_free;
  assign alloc_err = r_alloc_err;

  a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
    (r_state != RUN) || (w_budget >= CW'(w_acnt)));
endmodule

// File: tb/tb_pr_alloc_ctrl.sv
// Directed scoreboard bench for pr_alloc_ctrl: driver queues expectations, monitor checks them.
module tb_pr_alloc_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] disp_valid = '0, disp_needs_pr = '0, retire_valid = '0, fl_grant_valid = '1;
  logic [1:0] disp_limit = 2'd3;
  logic       br_recover_enable = 1'b0;
  logic [2:0] new_pr_en, disp_en;
  logic       stall, low_free, alloc_err;
  logic [6:0] free_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      nm;
    logic [5:0] chk;
    logic [2:0] en, pr;
    logic       st;
    logic [6:0] fc;
    logic       lf, err;
  } exp_t;
  exp_t q[$];

  pr_alloc_ctrl dut (
    .clock(clock), .reset(reset), .disp_valid(disp_valid), .disp_needs_pr(disp_needs_pr),
    .disp_limit(disp_limit), .retire_valid(retire_valid), .br_recover_enable(br_recover_enable),
    .fl_grant_valid(fl_grant_valid), .new_pr_en(new_pr_en), .disp_en(disp_en), .stall(stall),
    .free_cnt(free_cnt), .low_free(low_free), .alloc_err(alloc_err)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string nm, input string f, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s %s: got %0h expected %0h", nm, f, got, want);
    end
  endtask

  task automatic cyc(input string nm, input logic rst, input logic [2:0] v, input logic [2:0] n,
                     input logic [1:0] lim, input logic [2:0] ret, input logic br, input logic [2:0] g,
                     input logic [2:0] een, input logic [2:0] epr, input logic est, input int efc,
                     input logic elf, input logic eerr);
    exp_t e;
    @(negedge clock);
    reset = rst; disp_valid = v; disp_needs_pr = n; disp_limit = lim;
    retire_valid = ret; br_recover_enable = br; fl_grant_valid = g;
    e.nm = nm; e.chk = 6'h3F; e.en = een; e.pr = epr; e.st = est;
    e.fc = 7'(efc); e.lf = elf; e.err = eerr;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.chk[0]) cmp(e.nm, "disp_en", 32'(disp_en), 32'(e.en));
        if (e.chk[1]) cmp(e.nm, "new_pr_en", 32'(new_pr_en), 32'(e.pr));
        if (e.chk[2]) cmp(e.nm, "stall", 32'(stall), 32'(e.st));
        if (e.chk[3]) cmp(e.nm, "free_cnt", 32'(free_cnt), 32'(e.fc));
        if (e.chk[4]) cmp(e.nm, "low_free", 32'(low_free), 32'(e.lf));
        if (e.chk[5]) cmp(e.nm, "alloc_err", 32'(alloc_err), 32'(e.err));
      end
    end
  end

  initial begin : driver
    int bound;
    //             name        rst v     n     lim   ret   br g     en    pr    st fc  lf err
    for (int k = 0; k < 3; k++)
      cyc("reset",    0, 3'd0, 3'd0, 2'd3, 3'd0, 0, 3'd7, 3'd0, 3'd0, 1, 32, 0, 0);
    cyc("init",       1, 3'd7, 3'd7, 2'd3, 3'd0, 1, 3'd7, 3'd0, 3'd0, 1, 32, 0, 0);
    cyc("run_idle",   1, 3'd0, 3'd0, 2'd3, 3'd0, 0, 3'd7, 3'd0, 3'd0, 0, 32, 0, 0);
    for (int k = 0; k < 10; k++)
      cyc("alloc3",   1, 3'd7, 3'd7, 2'd3, 3'd0, 0, 3'd7, 3'd7, 3'd7, 0, 32 - 3*k, 0, 0);
    cyc("alloc1",     1, 3'd1, 3'd1, 2'd3, 3'd0, 0, 3'd7, 3'd1, 3'd1, 0, 2, 1, 0);
    cyc("fc1_block",  1, 3'd7, 3'd5, 2'd3, 3'd0, 0, 3'd7, 3'd3, 3'd1, 1, 1, 1, 0);
    cyc("retire1",    1, 3'd0, 3'd0, 2'd3, 3'd1, 0, 3'd7, 3'd0, 3'd0, 0, 0, 1, 0);
    cyc("fc1_retire", 1, 3'd7, 3'd5, 2'd3, 3'd2, 0, 3'd7, 3'd7, 3'd5, 0, 1, 1, 0);
    cyc("fc0_nopr",   1, 3'd7, 3'd2, 2'd3, 3'd0, 0, 3'd7, 3'd1, 3'd0, 1, 0, 1, 0);
    cyc("retire3",    1, 3'd0, 3'd0, 2'd3, 3'd7, 0, 3'd7, 3'd0, 3'd0, 0, 0, 1, 0);
    cyc("retire2",    1, 3'd0, 3'd0, 2'd3, 3'd3, 0, 3'd7, 3'd0, 3'd0, 0, 3, 0, 0);
    cyc("br_cycle",   1, 3'd7, 3'd7, 2'd3, 3'd7, 1, 3'd7, 3'd0, 3'd0, 1, 5, 0, 0);
    cyc("recover",    1, 3'd7, 3'd7, 2'd3, 3'd0, 0, 3'd7, 3'd0, 3'd0, 1, 32, 0, 0);
    cyc("post_rec",   1, 3'd0, 3'd0, 2'd3, 3'd0, 0, 3'd7, 3'd0, 3'd0, 0, 32, 0, 0);
    cyc("limit1",     1, 3'd7, 3'd0, 2'd1, 3'd0, 0, 3'd7, 3'd1, 3'd0, 1, 32, 0, 0);
    cyc("limit0",     1, 3'd7, 3'd0, 2'd0, 3'd0, 0, 3'd7, 3'd0, 3'd0, 1, 32, 0, 0);
    cyc("overflow",   1, 3'd0, 3'd0, 2'd3, 3'd1, 0, 3'd7, 3'd0, 3'd0, 0, 32, 0, 0);
    cyc("ovf_err",    1, 3'd0, 3'd0, 2'd3, 3'd0, 0, 3'd7, 3'd0, 3'd0, 0, 32, 0, 1);
    cyc("reset2",     0, 3'd0, 3'd0, 2'd3, 3'd0, 0, 3'd7, 3'd0, 3'd0, 1, 32, 0, 0);
    cyc("init2_br",   1, 3'd0, 3'd0, 2'd3, 3'd0, 1, 3'd7, 3'd0, 3'd0, 1, 32, 0, 0);
    cyc("no_grant",   1, 3'd1, 3'd1, 2'd3, 3'd0, 0, 3'd0, 3'd1, 3'd1, 0, 32, 0, 0);
    for (int k = 0; k < 4; k++)
      cyc("err_sticky", 1, 3'd0, 3'd0, 2'd3, 3'd0, 0, 3'd7, 3'd0, 3'd0, 0, 31, 0, 1);
    bound = 0;
    while (q.size() != 0 && bound < 20) begin
      @(negedge clock);
      bound++;
    end
    #5;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
